// File: rtl/i2s_pkg.sv
// Shared constants and types for the I2S ADC receive path.
package i2s_pkg;

    // Default bits per channel word.
    localparam int SAMPLE_W_DEF = 16;

    // Word-capture FSM states.
    typedef enum logic [1:0] {
        ST_SYNC  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2
    } rx_state_t;

    // The slot counter must be able to count up to sample_w.
    function automatic int slot_cnt_width(input int sample_w);
        return $clog2(sample_w + 1);
    endfunction

    localparam int SLOT_CNT_W = slot_cnt_width(SAMPLE_W_DEF);

endpackage

// File: rtl/i2s_sample_fifo.sv
// Synchronous FIFO of stereo pairs.
// The head output reads zero while the FIFO is empty.
// DEPTH must be a power of two and at least 2, so the pointers wrap naturally.
module i2s_sample_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk100,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_pop;
    logic             do_push;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
    assign do_push = push & (~full | do_pop);
    assign head    = empty ? '0 : mem[rd_ptr];

    // Storage array; written only on an accepted push.
    always_ff @(posedge clk100) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk100 or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/i2s_adc_rx.sv
// I2S ADC receiver: synchronises the codec serial lines into clk100,
// assembles left/right words and queues complete stereo pairs.
module i2s_adc_rx
    import i2s_pkg::*;
#(
    parameter int SAMPLE_W    = SAMPLE_W_DEF,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk100,
    input  logic                rst,
    input  logic                enable_i,
    input  logic                bclk_i,
    input  logic                lrclk_i,
    input  logic                adcdat_i,
    output logic [SAMPLE_W-1:0] sample_left_o,
    output logic [SAMPLE_W-1:0] sample_right_o,
    output logic                sample_valid_o,
    input  logic                sample_ready_i,
    output logic                overflow_o,
    output logic                short_err_o
);

    localparam int CNT_W  = slot_cnt_width(SAMPLE_W);
    localparam int PAIR_W = 2 * SAMPLE_W;

    logic [SYNC_STAGES-1:0] bclk_sync;
    logic [SYNC_STAGES-1:0] lr_sync;
    logic [SYNC_STAGES-1:0] dat_sync;
    logic                   bclk_s;
    logic                   lr_s;
    logic                   dat_s;
    logic                   bclk_prev;
    logic                   bit_event;

    rx_state_t              state;
    rx_state_t              state_next;
    logic                   lr_prev;
    logic                   lr_seen;
    logic                   slot0;
    logic                   chan;
    logic [CNT_W-1:0]       slot_cnt;
    logic [SAMPLE_W-1:0]    shift_reg;
    logic [SAMPLE_W-1:0]    word_next;
    logic [SAMPLE_W-1:0]    pending_left;
    logic                   left_ok;
    logic                   shift_en;
    logic                   word_done;
    logic                   short_det;

    logic                   push_req;
    logic                   pop;
    logic [PAIR_W-1:0]      fifo_head;
    logic                   fifo_empty;
    logic                   fifo_full;

    assign bclk_s    = bclk_sync[SYNC_STAGES-1];
    assign lr_s      = lr_sync[SYNC_STAGES-1];
    assign dat_s     = dat_sync[SYNC_STAGES-1];
    assign bit_event = bclk_s & ~bclk_prev;
    // A channel boundary needs a reference lrclk from an earlier bit event.
    assign slot0     = bit_event & lr_seen & (lr_s != lr_prev);
    assign word_next = {shift_reg[SAMPLE_W-2:0], dat_s};
    assign push_req  = word_done & chan & left_ok;
    assign pop       = ~fifo_empty & sample_ready_i;

    // Synchroniser chains for the asynchronous codec lines plus bclk edge history.
    always_ff @(posedge clk100 or posedge rst) begin
        if (rst) begin
            bclk_sync <= '0;
            lr_sync   <= '0;
            dat_sync  <= '0;
            bclk_prev <= 1'b0;
        end else begin
            bclk_sync <= {bclk_sync[SYNC_STAGES-2:0], bclk_i};
            lr_sync   <= {lr_sync[SYNC_STAGES-2:0], lrclk_i};
            dat_sync  <= {dat_sync[SYNC_STAGES-2:0], adcdat_i};
            bclk_prev <= bclk_s;
        end
    end

    // FSM state register.
    always_ff @(posedge clk100 or posedge rst) begin
        if (rst) begin
            state <= ST_SYNC;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and per-bit-event control decisions.
    always_comb begin
        state_next = state;
        shift_en   = 1'b0;
        word_done  = 1'b0;
        short_det  = 1'b0;
        if (!enable_i) begin
            state_next = ST_SYNC;
        end else if (bit_event) begin
            case (state)
                ST_SYNC: begin
                    if (slot0) begin
                        state_next = ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (slot0) begin
                        short_det = 1'b1;
                    end else begin
                        shift_en = 1'b1;
                        if (slot_cnt == CNT_W'(SAMPLE_W - 1)) begin
                            word_done  = 1'b1;
                            state_next = ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (slot0) begin
                        state_next = ST_SHIFT;
                    end
                end
                default: state_next = ST_SYNC;
            endcase
        end
    end

    // Word assembly, left pairing and registered error pulses.
    always_ff @(posedge clk100 or posedge rst) begin
        if (rst) begin
            lr_prev      <= 1'b0;
            lr_seen      <= 1'b0;
            chan         <= 1'b0;
            slot_cnt     <= '0;
            shift_reg    <= '0;
            pending_left <= '0;
            left_ok      <= 1'b0;
            short_err_o  <= 1'b0;
            overflow_o   <= 1'b0;
        end else begin
            short_err_o <= short_det;
            overflow_o  <= push_req & fifo_full & ~pop;
            if (!enable_i) begin
                lr_seen  <= 1'b0;
                left_ok  <= 1'b0;
                slot_cnt <= '0;
            end else if (bit_event) begin
                lr_prev <= lr_s;
                lr_seen <= 1'b1;
                if (slot0) begin
                    slot_cnt <= '0;
                    chan     <= lr_s;
                end else if (shift_en) begin
                    shift_reg <= word_next;
                    slot_cnt  <= slot_cnt + CNT_W'(1);
                end
                if (short_det) begin
                    left_ok <= 1'b0;
                end
                if (word_done) begin
                    if (!chan) begin
                        pending_left <= word_next;
                        left_ok      <= 1'b1;
                    end else begin
                        left_ok <= 1'b0;
                    end
                end
            end
        end
    end

    i2s_sample_fifo #(
        .WIDTH (PAIR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk100    (clk100),
        .rst       (rst),
        .push      (push_req),
        .push_data ({pending_left, word_next}),
        .pop       (pop),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign sample_valid_o = ~fifo_empty;
    assign sample_left_o  = fifo_head[PAIR_W-1:SAMPLE_W];
    assign sample_right_o = fifo_head[SAMPLE_W-1:0];

endmodule
